// File: rtl/interval_meter_pkg.sv
// Shared state encoding for the interval meter and its saturating counter.
package interval_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DW_DEFAULT = 12;

endpackage

// File: rtl/interval_meter_sat_upcounter.sv
// Up-counter that loads 1 on clear and sticks at MAX_COUNT, flagging saturation.
module sat_upcounter #(
  parameter int             DW        = 12,
  parameter logic [DW-1:0]  MAX_COUNT = {DW{1'b1}}
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clear,
  input  logic          i_en,
  output logic [DW-1:0] o_value,
  output logic          o_sat
);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_value <= '0;
      o_sat   <= 1'b0;
    end else if (i_clear) begin
      o_value <= DW'(1);
      o_sat   <= 1'b0;
    end else if (i_en) begin
      // Compare before incrementing so the value can never wrap.
      if (o_value == MAX_COUNT) begin
        o_sat <= 1'b1;
      end else begin
        o_value <= o_value + DW'(1);
      end
    end
  end

endmodule

// File: rtl/interval_meter.sv
// Measures cycles from a start event to a stop event and returns the count
// over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for i_start
// COUNT | counter running, waiting for i_stop
// HOLD  | result presented on o_valid until the consumer takes it
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int             DW        = DW_DEFAULT,
  parameter logic [DW-1:0]  MAX_COUNT = {DW{1'b1}}
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic          i_stop,
  output logic          o_busy,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_count,
  output logic          o_overflow
);

  state_e        state;
  logic          cnt_clear;
  logic          cnt_en;
  logic [DW-1:0] cnt_value;
  logic          cnt_sat;

  // A new measurement starts from IDLE or straight out of an accepted HOLD.
  assign cnt_clear = i_start && ((state == ST_IDLE) || ((state == ST_HOLD) && i_ready));
  assign cnt_en    = (state == ST_COUNT) && !i_stop;

  sat_upcounter #(
    .DW        (DW),
    .MAX_COUNT (MAX_COUNT)
  ) u_counter (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (cnt_clear),
    .i_en      (cnt_en),
    .o_value   (cnt_value),
    .o_sat     (cnt_sat)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state  <= ST_COUNT;
            o_busy <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (i_stop) begin
            state      <= ST_HOLD;
            o_busy     <= 1'b0;
            o_valid    <= 1'b1;
            o_count    <= cnt_value;
            o_overflow <= cnt_sat;
          end
        end
        ST_HOLD: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (i_start) begin
              state  <= ST_COUNT;
              o_busy <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

  a_valid_stable: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_count) && $stable(o_overflow)));

  a_busy_valid_excl: assert property (@(posedge i_clk) !(o_busy && o_valid));

  a_count_nonzero: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (state == ST_COUNT) |-> (cnt_value != '0));

endmodule

// File: tb/tb_interval_meter.sv
// Scoreboard bench driving a default-width meter and a MAX_COUNT=8 meter in lockstep.
module tb_interval_meter;

  localparam int DW = 12;

  typedef struct packed {
    logic [DW-1:0] count;
    logic          ovf;
  } res_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic          ready = 1'b0;
  logic          busy_a, valid_a, ovf_a;
  logic [DW-1:0] count_a;
  logic          busy_b, valid_b, ovf_b;
  logic [DW-1:0] count_b;

  int   tests_run    = 0;
  int   tests_failed = 0;
  res_t q_a[$];
  res_t q_b[$];
  res_t exp_a, exp_b;

  always #5 clk = ~clk;

  interval_meter #(.DW(DW)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_stop(stop),
    .o_busy(busy_a), .o_valid(valid_a), .i_ready(ready),
    .o_count(count_a), .o_overflow(ovf_a)
  );

  interval_meter #(.DW(DW), .MAX_COUNT(12'd8)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_stop(stop),
    .o_busy(busy_b), .o_valid(valid_b), .i_ready(ready),
    .o_count(count_b), .o_overflow(ovf_b)
  );

  function automatic res_t model(input int n, input int maxc);
    res_t r;
    if (n > maxc) begin
      r.count = DW'(maxc);
      r.ovf   = 1'b1;
    end else begin
      r.count = DW'(n);
      r.ovf   = 1'b0;
    end
    return r;
  endfunction

  // Results are compared when a handshake is about to complete.
  always @(negedge clk) begin
    if (rst_n && valid_a && ready) begin
      tests_run++;
      if (q_a.size() == 0) begin
        tests_failed++;
        $display("FAIL result_a: got count=%0d ovf=%0d, expected no result", count_a, ovf_a);
      end else begin
        exp_a = q_a.pop_front();
        if (count_a !== exp_a.count || ovf_a !== exp_a.ovf) begin
          tests_failed++;
          $display("FAIL result_a: got count=%0d ovf=%0d, expected count=%0d ovf=%0d",
                   count_a, ovf_a, exp_a.count, exp_a.ovf);
        end
      end
    end
    if (rst_n && valid_b && ready) begin
      tests_run++;
      if (q_b.size() == 0) begin
        tests_failed++;
        $display("FAIL result_b: got count=%0d ovf=%0d, expected no result", count_b, ovf_b);
      end else begin
        exp_b = q_b.pop_front();
        if (count_b !== exp_b.count || ovf_b !== exp_b.ovf) begin
          tests_failed++;
          $display("FAIL result_b: got count=%0d ovf=%0d, expected count=%0d ovf=%0d",
                   count_b, ovf_b, exp_b.count, exp_b.ovf);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start at the next edge k, stop sampled at edge k+n; returns just after edge k+n.
  task automatic measure(input int n, input bit push);
    start = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0 || busy_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_on: got busy=%b/%b valid=%b, expected busy=1/1 valid=0", busy_a, busy_b, valid_a);
    end
    if (push) begin
      q_a.push_back(model(n, 4095));
      q_b.push_back(model(n, 8));
    end
    repeat (n - 1) step();
    tests_run++;
    if (valid_a !== 1'b0 || busy_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_stop: got valid=%b busy=%b, expected valid=0 busy=1", valid_a, busy_a);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++;
    if (valid_a !== 1'b1 || busy_a !== 1'b0 || valid_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL valid_rise: got valid=%b/%b busy=%b, expected valid=1/1 busy=0", valid_a, valid_b, busy_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    tests_run++;
    if ({busy_a, valid_a, ovf_a, count_a} !== '0 || {busy_b, valid_b, ovf_b, count_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got a=%b%b%b/%0d b=%b%b%b/%0d, expected all zero",
               busy_a, valid_a, ovf_a, count_a, busy_b, valid_b, ovf_b, count_b);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    ready = 1'b1;
    repeat (5) step();
    measure(5, 1'b1);
    tests_run++;
    if (count_a !== 12'd5 || ovf_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d ovf=%b, expected 5 ovf=0", count_a, ovf_a);
    end
    step();
    tests_run++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_idle: got valid=%b busy=%b, expected 0 0", valid_a, busy_a);
    end
  endtask

  task automatic test_min_and_collision();
    ready = 1'b1;
    measure(1, 1'b1);
    step();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    tests_run++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_stop_idle: got busy=%b valid=%b, expected busy=1 valid=0", busy_a, valid_a);
    end
    q_a.push_back(model(4, 4095));
    q_b.push_back(model(4, 8));
    repeat (3) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++;
    if (valid_a !== 1'b1 || count_a !== 12'd4) begin
      tests_failed++;
      $display("FAIL collide_count: got valid=%b count=%0d, expected valid=1 count=4", valid_a, count_a);
    end
    step();
  endtask

  task automatic test_saturation();
    ready = 1'b1;
    measure(8, 1'b1);
    step();
    measure(9, 1'b1);
    step();
    measure(20, 1'b1);
    tests_run++;
    if (count_b !== 12'd8 || ovf_b !== 1'b1 || count_a !== 12'd20 || ovf_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_20: got b=%0d/%b a=%0d/%b, expected b=8/1 a=20/0", count_b, ovf_b, count_a, ovf_a);
    end
    step();
  endtask

  task automatic test_hold_stall();
    ready = 1'b0;
    measure(12, 1'b1);
    for (int i = 0; i < 7; i++) begin
      start = i[0];
      stop  = ~i[0];
      step();
      tests_run++;
      if (valid_a !== 1'b1 || count_a !== 12'd12 || ovf_a !== 1'b0 || busy_a !== 1'b0 ||
          valid_b !== 1'b1 || count_b !== 12'd8 || ovf_b !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_stable[%0d]: got a=%b/%0d/%b busy=%b b=%b/%0d/%b, expected a=1/12/0 busy=0 b=1/8/1",
                 i, valid_a, count_a, ovf_a, busy_a, valid_b, count_b, ovf_b);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    ready = 1'b1;
    step();
    tests_run++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || valid_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_accept: got valid=%b/%b busy=%b, expected 0/0 0", valid_a, valid_b, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    measure(4, 1'b1);
    step();
    ready = 1'b1;
    measure(3, 1'b1);
    tests_run++;
    if (count_a !== 12'd3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d, expected 3", count_a);
    end
    step();
  endtask

  task automatic test_reset_mid();
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({busy_a, valid_a, ovf_a, count_a} !== '0 || {busy_b, valid_b, ovf_b, count_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_count: got a=%b%b%b/%0d b=%b%b%b/%0d, expected all zero",
               busy_a, valid_a, ovf_a, count_a, busy_b, valid_b, ovf_b, count_b);
    end
    rst_n = 1'b1;
    ready = 1'b0;
    step();
    measure(11, 1'b0);
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({busy_a, valid_a, ovf_a, count_a} !== '0 || {busy_b, valid_b, ovf_b, count_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold: got a=%b%b%b/%0d b=%b%b%b/%0d, expected all zero",
               busy_a, valid_a, ovf_a, count_a, busy_b, valid_b, ovf_b, count_b);
    end
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    measure(7, 1'b1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_min_and_collision();
    test_saturation();
    test_hold_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (2) step();
    tests_run++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d/%0d pending results, expected 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
